// File: rtl/icache_refill_responder_pkg.sv
// ----------------------------------------------------------------------------
// icache_refill_responder_pkg
//
// Shared definitions for the instruction-cache refill responder:
//   - refill_state_e : refill controller states (IDLE, FETCH, RESPOND)
//   - helper functions that derive the dependent widths from the top-level
//     parameters, so the top and its arbiter size things the same way.
// No ports (package).
// ----------------------------------------------------------------------------
package icache_refill_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        RESPOND = 2'd2
    } refill_state_e;

    // Width of a cache id; a single cache still needs one bit to name it.
    function automatic int cache_id_width(input int num_caches);
        return (num_caches > 1) ? $clog2(num_caches) : 1;
    endfunction

    // Cacheline address width: the word address minus the beat index bits.
    function automatic int cacheline_addr_width(input int pc_width, input int idx_bits);
        return pc_width - idx_bits;
    endfunction

    function automatic int beats_per_line(input int idx_bits);
        return 1 << idx_bits;
    endfunction

    // One extra bit so the beat counters can reach BeatsPerLine without wrapping.
    function automatic int beat_count_width(input int idx_bits);
        return idx_bits + 1;
    endfunction

endpackage

// File: rtl/icache_refill_responder_rr_arbiter_onehot.sv
// ----------------------------------------------------------------------------
// rr_arbiter_onehot
//
// Round-robin arbiter with a one-hot grant. The grant is combinational: the
// first requester at or after the pointer wins. The pointer only moves when
// the grant is actually accepted, and then points just past the winner.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset (pointer -> 0)
//   req        in   NumReq request vector
//   accept     in   grant taken this cycle; advance the pointer
//   grant      out  NumReq one-hot (or zero) grant
//   grant_idx  out  binary index of the granted requester
// ----------------------------------------------------------------------------
module rr_arbiter_onehot
    import icache_refill_responder_pkg::*;
#(
    parameter int NumReq = 2,
    localparam int IdxWidth = cache_id_width(NumReq)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumReq-1:0]   req,
    input  logic                accept,
    output logic [NumReq-1:0]   grant,
    output logic [IdxWidth-1:0] grant_idx
);

    logic [IdxWidth-1:0] ptr;
    logic                found;

    // Two passes give the wrap-around priority: first the requesters at or
    // above the pointer, then the ones below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int c = 0; c < NumReq; c++) begin
            if (!found && req[c] && (c >= int'(ptr))) begin
                found     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = IdxWidth'(c);
            end
        end
        for (int c = 0; c < NumReq; c++) begin
            if (!found && req[c] && (c < int'(ptr))) begin
                found     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = IdxWidth'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && found) begin
            if (int'(grant_idx) == NumReq - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_refill_responder.sv
// ----------------------------------------------------------------------------
// icache_refill_responder
//
// Responder end of the instruction-cache refill protocol. Accepts cacheline
// refill requests from NumCaches instruction caches (round-robin), fetches
// the line from a shared word-wide instruction memory one instruction per
// beat, assembles it, and returns it with a one-cycle valid pulse to the
// requesting cache. One refill is in flight at a time.
//
// Ports:
//   clk_i         in   clock
//   rst_i         in   asynchronous active-high reset
//   ic_req_i      in   [NumCaches]       per-cache refill request (held)
//   ic_addr_i     in   [NumCaches*CLAW]  per-cache line address, cache c at
//                                        bits [c*CLAW +: CLAW]
//   ic_ready_o    out  [NumCaches]       request accept, one-hot or zero
//   ic_valid_o    out  [NumCaches]       response pulse, one-hot or zero
//   ic_data_o     out  [BeatsPerLine*EncInstWidth] response line, word 0
//                                        (lowest PC) in the lowest bits
//   mem_req_o     out  memory read request
//   mem_addr_o    out  [PcWidth] word address = {line, beat index}
//   mem_gnt_i     in   memory accepts the request this cycle
//   mem_rvalid_i  in   read data valid (in order, >=1 cycle after grant)
//   mem_rdata_i   in   [EncInstWidth] read data
// ----------------------------------------------------------------------------
module icache_refill_responder
    import icache_refill_responder_pkg::*;
#(
    parameter int NumCaches        = 2,
    parameter int PcWidth          = 32,
    parameter int EncInstWidth     = 32,
    parameter int CachelineIdxBits = 2,
    localparam int CachelineAddrWidth = cacheline_addr_width(PcWidth, CachelineIdxBits),
    localparam int CacheIdWidth       = cache_id_width(NumCaches),
    localparam int BeatsPerLine       = beats_per_line(CachelineIdxBits),
    localparam int CntWidth           = beat_count_width(CachelineIdxBits)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumCaches-1:0]                   ic_req_i,
    input  logic [NumCaches*CachelineAddrWidth-1:0] ic_addr_i,
    output logic [NumCaches-1:0]                   ic_ready_o,
    output logic [NumCaches-1:0]                   ic_valid_o,
    output logic [BeatsPerLine*EncInstWidth-1:0]   ic_data_o,
    output logic                                   mem_req_o,
    output logic [PcWidth-1:0]                     mem_addr_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [EncInstWidth-1:0]                mem_rdata_i
);

    // Line address and instruction word types, shared in shape with the
    // instruction cache.
    localparam type cacheline_addr_t = logic [CachelineAddrWidth-1:0];
    localparam type inst_t           = logic [EncInstWidth-1:0];

    refill_state_e           state;
    logic [CacheIdWidth-1:0] id_q;
    cacheline_addr_t         line_q;
    logic [CntWidth-1:0]     issued_q;
    logic [CntWidth-1:0]     received_q;
    inst_t                   buffer_q [BeatsPerLine];

    logic [NumCaches-1:0]    grant;
    logic [CacheIdWidth-1:0] grant_idx;
    logic                    accept;
    cacheline_addr_t         sel_addr;
    logic [PcWidth-1:0]      fetch_addr;

    rr_arbiter_onehot #(
        .NumReq (NumCaches)
    ) u_arb (
        .clk       (clk_i),
        .rst       (rst_i),
        .req       (ic_req_i),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The arbiter's grant already implies a request, so ready doubles as the
    // handshake. Gating with rst_i keeps ready low while reset is asserted.
    assign accept     = (state == IDLE) && !rst_i && (|grant);
    assign ic_ready_o = accept ? grant : '0;

    always_comb begin
        sel_addr = '0;
        for (int c = 0; c < NumCaches; c++) begin
            if (grant[c]) begin
                sel_addr = ic_addr_i[c*CachelineAddrWidth +: CachelineAddrWidth];
            end
        end
    end

    // With a single-beat line there is no beat index to append.
    generate
        if (CachelineIdxBits == 0) begin : g_addr_line
            assign fetch_addr = line_q;
        end else begin : g_addr_beat
            assign fetch_addr = {line_q, issued_q[CachelineIdxBits-1:0]};
        end
    endgenerate

    assign mem_req_o  = (state == FETCH) && (issued_q < CntWidth'(BeatsPerLine));
    assign mem_addr_o = mem_req_o ? fetch_addr : '0;

    always_comb begin
        ic_valid_o = '0;
        for (int c = 0; c < NumCaches; c++) begin
            ic_valid_o[c] = (state == RESPOND) && (int'(id_q) == c);
        end
    end

    always_comb begin
        ic_data_o = '0;
        if (state == RESPOND) begin
            for (int b = 0; b < BeatsPerLine; b++) begin
                ic_data_o[b*EncInstWidth +: EncInstWidth] = buffer_q[b];
            end
        end
    end

    // Issue and receive run concurrently in FETCH; a grant and an rvalid in
    // the same cycle each advance their own counter. The last rvalid moves
    // straight to RESPOND so the line is presented the following cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            id_q       <= '0;
            line_q     <= '0;
            issued_q   <= '0;
            received_q <= '0;
            for (int b = 0; b < BeatsPerLine; b++) begin
                buffer_q[b] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q       <= grant_idx;
                        line_q     <= sel_addr;
                        issued_q   <= '0;
                        received_q <= '0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_req_o && mem_gnt_i) begin
                        issued_q <= issued_q + 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        for (int b = 0; b < BeatsPerLine; b++) begin
                            if (int'(received_q) == b) begin
                                buffer_q[b] <= mem_rdata_i;
                            end
                        end
                        received_q <= received_q + 1'b1;
                        if (int'(received_q) == BeatsPerLine - 1) begin
                            state <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_rvalid_only_in_fetch: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> (state == FETCH));
    a_received_le_issued: assert property (@(posedge clk_i) disable iff (rst_i)
        received_q <= issued_q);
    a_valid_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(ic_valid_o));
    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(ic_ready_o));
`endif

endmodule

// File: tb/tb_icache_refill_responder.sv
// ----------------------------------------------------------------------------
// tb_icache_refill_responder
//
// Directed bench for icache_refill_responder. Two instances: the default
// configuration (2 caches, 4-beat lines) and a single-beat configuration.
// Each has a small memory model returning data == word address one cycle
// after grant; the default instance's model can stall grants on one beat.
// ----------------------------------------------------------------------------
module tb_icache_refill_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance: 2 caches, 32-bit PC, 4 beats per line.
    logic [1:0]   ic_req;
    logic [59:0]  ic_addr;
    logic [1:0]   ic_ready;
    logic [1:0]   ic_valid;
    logic [127:0] ic_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    // Single-beat instance.
    logic [1:0]   ic_req_z;
    logic [63:0]  ic_addr_z;
    logic [1:0]   ic_ready_z;
    logic [1:0]   ic_valid_z;
    logic [31:0]  ic_data_z;
    logic         mem_req_z;
    logic [31:0]  mem_addr_z;
    logic         mem_rvalid_z;
    logic [31:0]  mem_rdata_z;

    icache_refill_responder #(
        .NumCaches(2), .PcWidth(32), .EncInstWidth(32), .CachelineIdxBits(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr),
        .ic_ready_o(ic_ready), .ic_valid_o(ic_valid), .ic_data_o(ic_data),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    icache_refill_responder #(
        .NumCaches(2), .PcWidth(32), .EncInstWidth(32), .CachelineIdxBits(0)
    ) dut_z (
        .clk_i(clk), .rst_i(rst),
        .ic_req_i(ic_req_z), .ic_addr_i(ic_addr_z),
        .ic_ready_o(ic_ready_z), .ic_valid_o(ic_valid_z), .ic_data_o(ic_data_z),
        .mem_req_o(mem_req_z), .mem_addr_o(mem_addr_z), .mem_gnt_i(1'b1),
        .mem_rvalid_i(mem_rvalid_z), .mem_rdata_i(mem_rdata_z)
    );

    // Memory model for the default instance.
    int stall_beat = 99;
    int stall_len  = 0;
    int stall_cnt, gnt_cnt, rv_cnt, ov_cnt, b2_cnt;

    assign mem_gnt = !(mem_req && (int'(mem_addr[1:0]) == stall_beat) && (stall_cnt < stall_len));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            stall_cnt  <= 0;
            gnt_cnt    <= 0;
            rv_cnt     <= 0;
            ov_cnt     <= 0;
            b2_cnt     <= 0;
        end else begin
            mem_rvalid <= mem_req && mem_gnt;
            mem_rdata  <= mem_addr;
            if (mem_req && !mem_gnt) stall_cnt <= stall_cnt + 1;
            if (mem_req && mem_gnt) gnt_cnt <= gnt_cnt + 1;
            if (mem_rvalid) rv_cnt <= rv_cnt + 1;
            if (mem_req && mem_gnt && mem_rvalid) ov_cnt <= ov_cnt + 1;
            if (mem_req && mem_addr[1:0] == 2'd2) b2_cnt <= b2_cnt + 1;
        end
    end

    // Memory model for the single-beat instance (always grants).
    int          zreq_cnt;
    logic [31:0] zaddr_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rvalid_z <= 1'b0;
            mem_rdata_z  <= '0;
            zreq_cnt     <= 0;
            zaddr_last   <= '0;
        end else begin
            mem_rvalid_z <= mem_req_z;
            mem_rdata_z  <= mem_addr_z;
            if (mem_req_z) begin
                zreq_cnt   <= zreq_cnt + 1;
                zaddr_last <= mem_addr_z;
            end
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Call just after the accept edge; lat is the cycle (1 = first after
    // accept) on which ic_valid rose, or -1 on timeout.
    task automatic wait_valid(output int lat, output logic [1:0] v,
                              output logic [127:0] d, output logic rdy_seen);
        lat      = -1;
        v        = '0;
        d        = '0;
        rdy_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ic_ready != 2'b00) rdy_seen = 1'b1;
            if (ic_valid != 2'b00) begin
                lat = k;
                v   = ic_valid;
                d   = ic_data;
                break;
            end
        end
    endtask

    localparam logic [127:0] LINE10 = 128'h00000043_00000042_00000041_00000040;
    localparam logic [127:0] LINE01 = 128'h00000007_00000006_00000005_00000004;
    localparam logic [127:0] LINE02 = 128'h0000000b_0000000a_00000009_00000008;
    localparam logic [127:0] LINE20 = 128'h00000083_00000082_00000081_00000080;

    initial begin
        int          lat;
        logic [1:0]  v;
        logic [127:0] d;
        logic        rs;
        logic [1:0]  exp_id;

        ic_req    = 2'b11;
        ic_addr   = '0;
        ic_req_z  = '0;
        ic_addr_z = '0;

        // Reset state, with requests pending so ready must be held low.
        #1;
        check("rst_ready",    128'(ic_ready),  128'd0);
        check("rst_valid",    128'(ic_valid),  128'd0);
        check("rst_mem_req",  128'(mem_req),   128'd0);
        check("rst_mem_addr", 128'(mem_addr),  128'd0);
        check("rst_data",     ic_data,         128'd0);
        ic_req = 2'b00;

        // Single refill, cache0, line 0x10, overlapped grant/rvalid.
        do_reset();
        ic_req            = 2'b01;
        ic_addr[29:0]     = 30'h10;
        #1;
        check("single_ready", 128'(ic_ready), 128'h1);
        @(posedge clk);
        #1 ic_req = 2'b00;
        wait_valid(lat, v, d, rs);
        check("single_lat",   128'(lat), 128'd6);
        check("single_valid", 128'(v),   128'h1);
        check("single_data",  d,         LINE10);
        check("single_busy_ready", 128'(rs), 128'd0);
        @(negedge clk);
        check("single_pulse_end", 128'(ic_valid), 128'd0);
        check("single_data_idle", ic_data,        128'd0);
        check("single_grants",  128'(gnt_cnt), 128'd4);
        check("single_rvalids", 128'(rv_cnt),  128'd4);
        check("single_overlap", 128'(ov_cnt),  128'd3);
        check("single_beat2",   128'(b2_cnt),  128'd1);

        // Round-robin with both caches holding requests.
        do_reset();
        ic_req         = 2'b11;
        ic_addr[29:0]  = 30'h1;
        ic_addr[59:30] = 30'h2;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check("rr_ready", 128'(ic_ready), 128'(exp_id));
            @(posedge clk);
            wait_valid(lat, v, d, rs);
            check("rr_valid", 128'(v), 128'(exp_id));
            check("rr_data",  d, (i % 2 == 0) ? LINE01 : LINE02);
            check("rr_busy_ready", 128'(rs), 128'd0);
            @(negedge clk);
        end
        ic_req = 2'b00;

        // Stalled memory: beat 2 refused for 3 cycles; request from cache1.
        stall_beat = 2;
        stall_len  = 3;
        do_reset();
        ic_req         = 2'b10;
        ic_addr[59:30] = 30'h10;
        #1;
        check("stall_ready", 128'(ic_ready), 128'h2);
        @(posedge clk);
        #1 ic_req = 2'b00;
        wait_valid(lat, v, d, rs);
        check("stall_lat",    128'(lat),     128'd9);
        check("stall_valid",  128'(v),       128'h2);
        check("stall_data",   d,             LINE10);
        check("stall_beat2",  128'(b2_cnt),  128'd4);
        check("stall_grants", 128'(gnt_cnt), 128'd4);
        stall_beat = 99;
        stall_len  = 0;

        // Single-beat lines: line 0x7 on the second instance.
        do_reset();
        ic_req_z        = 2'b01;
        ic_addr_z[31:0] = 32'h7;
        #1;
        check("z_ready", 128'(ic_ready_z), 128'h1);
        @(posedge clk);
        #1 ic_req_z = 2'b00;
        lat = -1;
        v   = '0;
        d   = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ic_valid_z != 2'b00) begin
                lat = k;
                v   = ic_valid_z;
                d   = 128'(ic_data_z);
                break;
            end
        end
        check("z_lat",      128'(lat),        128'd3);
        check("z_valid",    128'(v),          128'h1);
        check("z_data",     d,                128'h7);
        check("z_reads",    128'(zreq_cnt),   128'd1);
        check("z_mem_addr", 128'(zaddr_last), 128'h7);

        // Reset in the middle of a fetch, after two beats have returned.
        do_reset();
        ic_req        = 2'b01;
        ic_addr[29:0] = 30'h10;
        @(posedge clk);
        #1 ic_req = 2'b00;
        repeat (4) @(negedge clk);
        check("mid_mem_req", 128'(mem_req), 128'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_mem_req",  128'(mem_req),  128'd0);
        check("mid_rst_mem_addr", 128'(mem_addr), 128'd0);
        check("mid_rst_valid",    128'(ic_valid), 128'd0);
        check("mid_rst_ready",    128'(ic_ready), 128'd0);
        check("mid_rst_data",     ic_data,        128'd0);
        @(negedge clk);
        rst           = 1'b0;
        ic_req        = 2'b01;
        ic_addr[29:0] = 30'h20;
        #1;
        check("refetch_ready", 128'(ic_ready), 128'h1);
        @(posedge clk);
        #1 ic_req = 2'b00;
        @(negedge clk);
        check("refetch_first_addr", 128'(mem_addr), 128'h80);
        wait_valid(lat, v, d, rs);
        check("refetch_lat",   128'(lat), 128'd5);
        check("refetch_valid", 128'(v),   128'h1);
        check("refetch_data",  d,         LINE20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
